// File: rtl/knap_pkg.sv
// knap_pkg: shared state type, dimension encoding and width helper
// for the exhaustive knapsack search engine.
package knap_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  localparam int DIM_VALUE = 0;
  localparam int DIM_FIRST = 1;

  function automatic int acc_w(input int w, input int n);
    return w + $clog2(n + 1);
  endfunction

endpackage

// File: rtl/knap_if.sv
// knap_if: config/limit write port, start and result bundle.
// feas_count exists only when KNAP_FEAS_COUNT_EN is defined.
interface knap_if #(
  parameter int N_ITEMS = 5,
  parameter int N_DIMS  = 2,
  parameter int W       = 7
) ();
  import knap_pkg::*;

  localparam int IW    = $clog2(N_ITEMS);
  localparam int DW    = $clog2(N_DIMS + 1);
  localparam int ACC_W = acc_w(W, N_ITEMS);

  logic               cfg_we;
  logic [IW-1:0]      cfg_item;
  logic [DW-1:0]      cfg_dim;
  logic [W-1:0]       cfg_data;
  logic               lim_we;
  logic [DW-1:0]      lim_dim;
  logic [ACC_W-1:0]   lim_data;
  logic               start;
  logic               busy;
  logic               done;
  logic               found;
  logic [N_ITEMS-1:0] best_mask;
  logic [ACC_W-1:0]   best_value;
`ifdef KNAP_FEAS_COUNT_EN
  logic [N_ITEMS:0]   feas_count;

  modport master (
    output cfg_we, cfg_item, cfg_dim, cfg_data,
    output lim_we, lim_dim, lim_data, start,
    input  busy, done, found, best_mask, best_value,
    input  feas_count
  );
  modport slave (
    input  cfg_we, cfg_item, cfg_dim, cfg_data,
    input  lim_we, lim_dim, lim_data, start,
    output busy, done, found, best_mask, best_value,
    output feas_count
  );
`else
  modport master (
    output cfg_we, cfg_item, cfg_dim, cfg_data,
    output lim_we, lim_dim, lim_data, start,
    input  busy, done, found, best_mask, best_value
  );
  modport slave (
    input  cfg_we, cfg_item, cfg_dim, cfg_data,
    input  lim_we, lim_dim, lim_data, start,
    output busy, done, found, best_mask, best_value
  );
`endif
endinterface

// File: rtl/knap_gray_step.sv
// knap_gray_step: step counter walking the Gray sequence; reports
// which item flips next, its direction, and the final step.
module knap_gray_step
  import knap_pkg::*;
#(
  parameter int N_ITEMS = 5,
  parameter int IW      = $clog2(N_ITEMS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_step,
  output logic [IW-1:0]      o_flip_idx,
  output logic               o_flip_add,
  output logic               o_last_step,
  output logic [N_ITEMS-1:0] o_mask
);

  logic [N_ITEMS-1:0] r_k;
  logic [N_ITEMS-1:0] w_gray;
  logic [IW-1:0]      w_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_k <= '0;
    else if (i_clear) r_k <= '0;
    else if (i_step)  r_k <= r_k + N_ITEMS'(1);
  end

  // ctz(k+1) is the lowest zero bit of k
  always_comb begin
    w_gray = r_k ^ (r_k >> 1);
    w_idx  = '0;
    for (int i = N_ITEMS - 1; i >= 0; i--)
      if (!r_k[i]) w_idx = IW'(i);
  end

  assign o_flip_idx  = w_idx;
  assign o_flip_add  = ~w_gray[w_idx];
  assign o_last_step = &r_k;
  assign o_mask      = w_gray;

endmodule

// File: rtl/knap_search.sv
// knap_search: exhaustive multi-constraint 0/1 knapsack search, one
// Gray-order subset per cycle. Optional KNAP_FEAS_COUNT_EN counter.
module knap_search
  import knap_pkg::*;
#(
  parameter int N_ITEMS = 5,
  parameter int N_DIMS  = 2,
  parameter int W       = 7
) (
  input logic   clk,
  input logic   rst_n,
  knap_if.slave bus
);

  localparam int IW    = $clog2(N_ITEMS);
  localparam int ACC_W = acc_w(W, N_ITEMS);

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_found;
  logic [N_ITEMS-1:0] r_best_mask;
  logic [ACC_W-1:0]   r_best_value;
  logic [W-1:0]       r_tab [N_ITEMS][N_DIMS+1];
  logic [ACC_W-1:0]   r_lim [N_DIMS+1];
  logic [ACC_W-1:0]   r_acc [N_DIMS+1];
`ifdef KNAP_FEAS_COUNT_EN
  localparam logic [N_ITEMS:0] FC_MAX = {1'b1, {N_ITEMS{1'b0}}};
  logic [N_ITEMS:0]   r_feas_count;
`endif

  logic [IW-1:0]      w_flip_idx;
  logic               w_flip_add;
  logic               w_last;
  logic [N_ITEMS-1:0] w_mask;
  logic               w_accept;
  logic               w_run;
  logic               w_feas;
  logic               w_better;

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_run    = (r_state == S_RUN);

  knap_gray_step #(.N_ITEMS(N_ITEMS)) u_step (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_accept),
    .i_step     (w_run),
    .o_flip_idx (w_flip_idx),
    .o_flip_add (w_flip_add),
    .o_last_step(w_last),
    .o_mask     (w_mask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ITEMS; i++)
        for (int d = 0; d <= N_DIMS; d++)
          r_tab[i][d] <= '0;
      for (int d = 0; d <= N_DIMS; d++)
        r_lim[d] <= '0;
    end else if (!r_busy) begin
      if (bus.cfg_we && int'(bus.cfg_item) < N_ITEMS &&
          int'(bus.cfg_dim) <= N_DIMS)
        r_tab[bus.cfg_item][bus.cfg_dim] <= bus.cfg_data;
      if (bus.lim_we && int'(bus.lim_dim) <= N_DIMS)
        r_lim[bus.lim_dim] <= bus.lim_data;
    end
  end

  always_comb begin
    w_feas = (r_acc[DIM_VALUE] >= r_lim[DIM_VALUE]);
    for (int d = DIM_FIRST; d <= N_DIMS; d++)
      if (r_acc[d] > r_lim[d]) w_feas = 1'b0;
  end

  assign w_better = w_feas &&
    (!r_found || r_acc[DIM_VALUE] > r_best_value);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_found      <= 1'b0;
      r_best_mask  <= '0;
      r_best_value <= '0;
      for (int d = 0; d <= N_DIMS; d++)
        r_acc[d] <= '0;
`ifdef KNAP_FEAS_COUNT_EN
      r_feas_count <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: if (bus.start) begin
          r_state      <= S_RUN;
          r_busy       <= 1'b1;
          r_found      <= 1'b0;
          r_best_mask  <= '0;
          r_best_value <= '0;
          for (int d = 0; d <= N_DIMS; d++)
            r_acc[d] <= '0;
`ifdef KNAP_FEAS_COUNT_EN
          r_feas_count <= '0;
`endif
        end
        S_RUN: begin
          if (w_better) begin
            r_found      <= 1'b1;
            r_best_mask  <= w_mask;
            r_best_value <= r_acc[DIM_VALUE];
          end
`ifdef KNAP_FEAS_COUNT_EN
          if (w_feas && r_feas_count != FC_MAX)
            r_feas_count <= r_feas_count + 1'b1;
`endif
          if (w_last) begin
            r_state <= S_FINISH;
            r_done  <= 1'b1;
          end else begin
            for (int d = 0; d <= N_DIMS; d++)
              if (w_flip_add)
                r_acc[d] <= r_acc[d] + ACC_W'(r_tab[w_flip_idx][d]);
              else
                r_acc[d] <= r_acc[d] - ACC_W'(r_tab[w_flip_idx][d]);
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.found      = r_found;
  assign bus.best_mask  = r_best_mask;
  assign bus.best_value = r_best_value;
`ifdef KNAP_FEAS_COUNT_EN
  assign bus.feas_count = r_feas_count;
`endif

endmodule

// File: tb/tb_knap_search.sv
// tb_knap_search: directed and randomized searches checked against
// a brute-force subset enumeration model.
module tb_knap_search;

  localparam int N  = 5;
  localparam int D  = 2;
  localparam int WD = 7;
  localparam int NS = 1 << N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   tv [N][D+1];
  int   tl [D+1];

  knap_if #(.N_ITEMS(N), .N_DIMS(D), .W(WD)) bus ();

  knap_search #(.N_ITEMS(N), .N_DIMS(D), .W(WD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic void model(output bit f, output int m,
                                output int v, output int c);
    f = 0; m = 0; v = 0; c = 0;
    for (int j = 0; j < NS; j++) begin
      int g;
      int s [D+1];
      bit ok;
      g = j ^ (j >> 1);
      for (int d = 0; d <= D; d++) begin
        s[d] = 0;
        for (int i = 0; i < N; i++)
          if (g[i]) s[d] += tv[i][d];
      end
      ok = (s[0] >= tl[0]);
      for (int d = 1; d <= D; d++)
        if (s[d] > tl[d]) ok = 0;
      if (ok) begin
        c++;
        if (!f || s[0] > v) begin
          f = 1; m = g; v = s[0];
        end
      end
    end
  endfunction

  task automatic set_defaults(input int min_v);
    int vals [N] = '{4, 8, 1, 20, 10};
    int d1 [N]   = '{28, 8, 27, 18, 27};
    int d2 [N]   = '{27, 27, 4, 4, 1};
    for (int i = 0; i < N; i++) begin
      tv[i][0] = vals[i]; tv[i][1] = d1[i]; tv[i][2] = d2[i];
    end
    tl[0] = min_v; tl[1] = 50; tl[2] = 50;
  endtask

  task automatic load_tables();
    for (int i = 0; i < N; i++)
      for (int d = 0; d <= D; d++) begin
        bus.cfg_we   = 1'b1;
        bus.cfg_item = 3'(i);
        bus.cfg_dim  = 2'(d);
        bus.cfg_data = 7'(tv[i][d]);
        @(negedge clk);
      end
    bus.cfg_we = 1'b0;
    for (int d = 0; d <= D; d++) begin
      bus.lim_we   = 1'b1;
      bus.lim_dim  = 2'(d);
      bus.lim_data = 10'(tl[d]);
      @(negedge clk);
    end
    bus.lim_we = 1'b0;
  endtask

  task automatic run_check(input string name, input bit disturb);
    bit ef;
    int em, ev, ec, n;
    logic [N-1:0] emask;
    model(ef, em, ev, ec);
    emask = em[N-1:0];
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    tests++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL %s busy_after_start: got %b exp 1", name, bus.busy);
    end
    while (bus.done !== 1'b1 && n < 200) begin
      if (disturb && n == 5) begin
        bus.start = 1'b1; bus.cfg_we = 1'b1;
        bus.cfg_item = 3'd3; bus.cfg_dim = 2'd0; bus.cfg_data = 7'd0;
      end else begin
        bus.start = 1'b0; bus.cfg_we = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0; bus.cfg_we = 1'b0;
    tests++;
    if (n != NS) begin
      fails++;
      $display("FAIL %s done_latency: got %0d exp %0d", name, n, NS);
    end
    tests++;
    if (bus.found !== ef) begin
      fails++;
      $display("FAIL %s found: got %b exp %b", name, bus.found, ef);
    end
    tests++;
    if (bus.best_mask !== emask) begin
      fails++;
      $display("FAIL %s best_mask: got %b exp %b", name, bus.best_mask, emask);
    end
    tests++;
    if (bus.best_value !== 10'(ev)) begin
      fails++;
      $display("FAIL %s best_value: got %0d exp %0d", name, bus.best_value, ev);
    end
`ifdef KNAP_FEAS_COUNT_EN
    tests++;
    if (bus.feas_count !== 6'(ec)) begin
      fails++;
      $display("FAIL %s feas_count: got %0d exp %0d", name, bus.feas_count, ec);
    end
`endif
    @(negedge clk);
    tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL %s done_busy_after: got %b%b exp 00", name, bus.done, bus.busy);
    end
  endtask

  task automatic check_zero(input string name);
    tests++;
    if ({bus.busy, bus.done, bus.found} !== 3'b000 ||
        bus.best_mask !== '0 || bus.best_value !== '0) begin
      fails++;
      $display("FAIL %s outputs: got b%b d%b f%b m%b v%0d exp all 0", name,
               bus.busy, bus.done, bus.found, bus.best_mask, bus.best_value);
    end
`ifdef KNAP_FEAS_COUNT_EN
    tests++;
    if (bus.feas_count !== '0) begin
      fails++;
      $display("FAIL %s feas_count: got %0d exp 0", name, bus.feas_count);
    end
`endif
  endtask

  task automatic test_reset();
    bus.cfg_we = 0; bus.cfg_item = 0; bus.cfg_dim = 0; bus.cfg_data = 0;
    bus.lim_we = 0; bus.lim_dim = 0; bus.lim_data = 0; bus.start = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("reset_release");
  endtask

  task automatic test_default();
    set_defaults(30); load_tables();
    run_check("default", 0);
    set_defaults(31); load_tables();
    run_check("min31", 0);
  endtask

  task automatic test_width();
    for (int i = 0; i < N; i++) begin
      tv[i][0] = 127; tv[i][1] = 0; tv[i][2] = 0;
    end
    tl[0] = 0; tl[1] = 0; tl[2] = 0;
    load_tables();
    run_check("width", 0);
  endtask

  task automatic test_tie();
    for (int i = 0; i < N; i++) begin
      tv[i][0] = (i < 2) ? 10 : 0;
      tv[i][1] = (i < 2) ? 30 : 41;
      tv[i][2] = 0;
    end
    tl[0] = 0; tl[1] = 40; tl[2] = 0;
    load_tables();
    run_check("tie", 0);
  endtask

  task automatic test_protocol();
    set_defaults(30); load_tables();
    run_check("protocol", 1);
    run_check("protocol_rerun", 0);
  endtask

  task automatic test_reset_midrun();
    set_defaults(30); load_tables();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      for (int d = 0; d <= D; d++) tv[i][d] = 0;
    for (int d = 0; d <= D; d++) tl[d] = 0;
    run_check("cleared_tables", 0);
    set_defaults(30); load_tables();
    run_check("after_reset", 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < N; i++)
        for (int d = 0; d <= D; d++) tv[i][d] = $urandom_range(0, 127);
      tl[0] = $urandom_range(0, 250);
      for (int d = 1; d <= D; d++) tl[d] = $urandom_range(0, 300);
      load_tables();
      run_check($sformatf("random%0d", t), 0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < N; i++)
      for (int d = 0; d <= D; d++) tv[i][d] = $urandom_range(0, 127);
    tl[0] = 100; tl[1] = 200; tl[2] = 200;
    load_tables();
    run_check("b2b_first", 0);
    run_check("b2b_second", 0);
  endtask

  initial begin
    test_reset();
    test_default();
    test_width();
    test_tie();
    test_protocol();
    test_reset_midrun();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
